// File: rtl/arith_issue_queue.sv
// Arithmetic issue queue: collapsing, age-ordered reservation station.
// Captures operands from the CDB and issues the oldest ready entry.
module arith_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             disp_valid_i,
  output logic             disp_ready_o,
  input  logic [31:0]      disp_pc_i,
  input  logic [31:0]      disp_inst_i,
  input  logic [TAG_W-1:0] disp_rd_tag_i,
  input  logic             disp_rs1_rdy_i,
  input  logic [TAG_W-1:0] disp_rs1_tag_i,
  input  logic [31:0]      disp_rs1_val_i,
  input  logic             disp_rs2_rdy_i,
  input  logic [TAG_W-1:0] disp_rs2_tag_i,
  input  logic [31:0]      disp_rs2_val_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_val_i,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [31:0]      issue_pc_o,
  output logic [31:0]      issue_inst_o,
  output logic [31:0]      issue_rs1_val_o,
  output logic [31:0]      issue_rs2_val_o,
  output logic [TAG_W-1:0] issue_rd_tag_o,
  output logic [CW-1:0]    count_o
);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [TAG_W-1:0] rd_tag;
    logic             rs1_rdy;
    logic [TAG_W-1:0] rs1_tag;
    logic [31:0]      rs1_val;
    logic             rs2_rdy;
    logic [TAG_W-1:0] rs2_tag;
    logic [31:0]      rs2_val;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          ext   [DEPTH+1];
  entry_t          new_e;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            lock_q;
  logic [IW-1:0]   lock_idx_q;
  logic [DEPTH-1:0] rdy_vec;
  logic [IW-1:0]   first_idx;
  logic [IW-1:0]   sel_idx;
  logic            found;
  logic            disp_fire;
  logic            issue_fire;
  int              tail;

  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    if (cdb_valid_i && !e.rs1_rdy && e.rs1_tag == cdb_tag_i) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = cdb_val_i;
    end
    if (cdb_valid_i && !e.rs2_rdy && e.rs2_tag == cdb_tag_i) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = cdb_val_i;
    end
    return r;
  endfunction

  always_comb begin
    rdy_vec   = '0;
    first_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy_vec[i] = (i < int'(cnt_q)) &&
                   ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy_vec[i] && !found) begin
        first_idx = IW'(i);
        found     = 1'b1;
      end
    end
  end

  // A stalled issue keeps its slot: only an issue can move entries.
  assign sel_idx       = lock_q ? lock_idx_q : first_idx;
  assign issue_valid_o = (|rdy_vec) | lock_q;
  assign issue_fire    = issue_valid_o & issue_ready_i;
  assign disp_ready_o  = cnt_q < CW'(DEPTH);
  assign disp_fire     = disp_valid_i & disp_ready_o;
  assign count_o       = cnt_q;

  assign issue_pc_o      = issue_valid_o ? ent_q[sel_idx].pc : '0;
  assign issue_inst_o    = issue_valid_o ? ent_q[sel_idx].inst : '0;
  assign issue_rs1_val_o = issue_valid_o ? ent_q[sel_idx].rs1_val : '0;
  assign issue_rs2_val_o = issue_valid_o ? ent_q[sel_idx].rs2_val : '0;
  assign issue_rd_tag_o  = issue_valid_o ? ent_q[sel_idx].rd_tag : '0;

  always_comb begin
    new_e.pc      = disp_pc_i;
    new_e.inst    = disp_inst_i;
    new_e.rd_tag  = disp_rd_tag_i;
    new_e.rs1_rdy = disp_rs1_rdy_i;
    new_e.rs1_tag = disp_rs1_tag_i;
    new_e.rs1_val = disp_rs1_val_i;
    new_e.rs2_rdy = disp_rs2_rdy_i;
    new_e.rs2_tag = disp_rs2_tag_i;
    new_e.rs2_val = disp_rs2_val_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ext[i] = ent_q[i];
    ext[DEPTH] = '0;
    tail = int'(cnt_q) - (issue_fire ? 1 : 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && i >= int'(sel_idx)) ent_d[i] = wake(ext[i+1]);
      else                                  ent_d[i] = wake(ext[i]);
      if (disp_fire && i == tail)           ent_d[i] = wake(new_e);
    end
    cnt_d = cnt_q + CW'(disp_fire) - CW'(issue_fire);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      if (issue_fire) begin
        lock_q <= 1'b0;
      end else if (issue_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_arith_issue_queue.sv
// Bench for arith_issue_queue: directed scenarios plus a randomized
// run checked against a queue-based reference model.
module tb_arith_issue_queue;

  logic        clk = 1'b0;
  logic        reset_i, flush_i;
  logic        disp_valid_i, disp_ready_o;
  logic [31:0] disp_pc_i, disp_inst_i;
  logic [3:0]  disp_rd_tag_i;
  logic        disp_rs1_rdy_i, disp_rs2_rdy_i;
  logic [3:0]  disp_rs1_tag_i, disp_rs2_tag_i;
  logic [31:0] disp_rs1_val_i, disp_rs2_val_i;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_val_i;
  logic        issue_valid_o, issue_ready_i;
  logic [31:0] issue_pc_o, issue_inst_o;
  logic [31:0] issue_rs1_val_o, issue_rs2_val_o;
  logic [3:0]  issue_rd_tag_o;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;

  arith_issue_queue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_pc_i(disp_pc_i), .disp_inst_i(disp_inst_i),
    .disp_rd_tag_i(disp_rd_tag_i),
    .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs1_tag_i(disp_rs1_tag_i),
    .disp_rs1_val_i(disp_rs1_val_i),
    .disp_rs2_rdy_i(disp_rs2_rdy_i), .disp_rs2_tag_i(disp_rs2_tag_i),
    .disp_rs2_val_i(disp_rs2_val_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i),
    .cdb_val_i(cdb_val_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_pc_o(issue_pc_o), .issue_inst_o(issue_inst_o),
    .issue_rs1_val_o(issue_rs1_val_o),
    .issue_rs2_val_o(issue_rs2_val_o),
    .issue_rd_tag_o(issue_rd_tag_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst;
    logic [3:0]  rd;
    logic        r1, r2;
    logic [3:0]  t1, t2;
    logic [31:0] v1, v2;
  } m_ent_t;

  m_ent_t mq[$];
  bit     mlock;
  int     mlidx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_i = 0; flush_i = 0; disp_valid_i = 0;
    disp_pc_i = 0; disp_inst_i = 0; disp_rd_tag_i = 0;
    disp_rs1_rdy_i = 0; disp_rs1_tag_i = 0; disp_rs1_val_i = 0;
    disp_rs2_rdy_i = 0; disp_rs2_tag_i = 0; disp_rs2_val_i = 0;
    cdb_valid_i = 0; cdb_tag_i = 0; cdb_val_i = 0;
    issue_ready_i = 0;
  endtask

  task automatic set_disp(input logic [31:0] pc, input logic r1,
                          input logic [3:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [3:0] t2,
                          input logic [31:0] v2, input logic [3:0] rd);
    disp_valid_i = 1; disp_pc_i = pc; disp_inst_i = pc ^ 32'h13;
    disp_rs1_rdy_i = r1; disp_rs1_tag_i = t1; disp_rs1_val_i = v1;
    disp_rs2_rdy_i = r2; disp_rs2_tag_i = t2; disp_rs2_val_i = v2;
    disp_rd_tag_i = rd;
  endtask

  task automatic do_flush();
    idle(); flush_i = 1; tick(); flush_i = 0;
  endtask

  task automatic test_reset();
    idle(); reset_i = 1; tick(); tick(); reset_i = 0; #1;
    checks++;
    if (count_o !== 3'd0) begin
      errors++; $display("FAIL reset_count got %0d want 0", count_o);
    end
    checks++;
    if (disp_ready_o !== 1'b1 || issue_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b v=%b want 1/0",
               disp_ready_o, issue_valid_o);
    end
    checks++;
    if ({issue_pc_o, issue_rs1_val_o, issue_rs2_val_o, issue_rd_tag_o}
        !== '0) begin
      errors++; $display("FAIL reset_data got pc=%h want 0", issue_pc_o);
    end
  endtask

  task automatic test_basic();
    idle(); set_disp(32'h100, 1, 0, 5, 1, 0, 7, 3); tick();
    idle(); #1;
    checks++;
    if (issue_valid_o !== 1 || issue_rs1_val_o !== 5 ||
        issue_rs2_val_o !== 7 || issue_rd_tag_o !== 3 ||
        issue_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL basic_issue got v=%b rs1=%0d rs2=%0d rd=%0d pc=%h want 1/5/7/3/100",
               issue_valid_o, issue_rs1_val_o, issue_rs2_val_o,
               issue_rd_tag_o, issue_pc_o);
    end
    issue_ready_i = 1; tick(); issue_ready_i = 0; #1;
    checks++;
    if (count_o !== 0 || issue_valid_o !== 0) begin
      errors++;
      $display("FAIL basic_drain got cnt=%0d v=%b want 0/0",
               count_o, issue_valid_o);
    end
  endtask

  task automatic test_wakeup();
    idle(); set_disp(32'h200, 0, 9, 0, 1, 0, 1, 2); tick();
    idle(); #1;
    checks++;
    if (issue_valid_o !== 0) begin
      errors++; $display("FAIL wake_wait got v=%b want 0", issue_valid_o);
    end
    tick();
    cdb_valid_i = 1; cdb_tag_i = 9; cdb_val_i = 32'hDEAD; #1;
    checks++;
    if (issue_valid_o !== 0) begin
      errors++;
      $display("FAIL wake_no_comb got v=%b want 0", issue_valid_o);
    end
    tick(); idle(); #1;
    checks++;
    if (issue_valid_o !== 1 || issue_rs1_val_o !== 32'hDEAD) begin
      errors++;
      $display("FAIL wake_issue got v=%b rs1=%h want 1/dead",
               issue_valid_o, issue_rs1_val_o);
    end
    issue_ready_i = 1; tick(); idle();
  endtask

  task automatic test_bypass();
    idle(); set_disp(32'h280, 1, 0, 32'h11, 0, 4, 0, 6);
    cdb_valid_i = 1; cdb_tag_i = 4; cdb_val_i = 32'h55; tick();
    idle(); #1;
    checks++;
    if (issue_valid_o !== 1 || issue_rs2_val_o !== 32'h55 ||
        issue_rs1_val_o !== 32'h11) begin
      errors++;
      $display("FAIL bypass got v=%b rs2=%h want 1/55",
               issue_valid_o, issue_rs2_val_o);
    end
    issue_ready_i = 1; tick(); idle();
  endtask

  task automatic test_stall_hold();
    do_flush();
    for (int i = 0; i < 4; i++) begin
      set_disp(32'h300 + 4 * i, 0, 4'(10 + i), 0, 1, 0, 0, 4'(i));
      tick();
    end
    idle(); #1;
    checks++;
    if (count_o !== 4 || disp_ready_o !== 0) begin
      errors++;
      $display("FAIL full_flags got cnt=%0d rdy=%b want 4/0",
               count_o, disp_ready_o);
    end
    cdb_valid_i = 1; cdb_tag_i = 12; cdb_val_i = 32'hA2; tick();
    cdb_tag_i = 10; cdb_val_i = 32'hA0; #1;
    checks++;
    if (issue_valid_o !== 1 || issue_pc_o !== 32'h308 ||
        issue_rs1_val_o !== 32'hA2) begin
      errors++;
      $display("FAIL stall_first got pc=%h rs1=%h want 308/a2",
               issue_pc_o, issue_rs1_val_o);
    end
    tick(); idle(); #1;
    checks++;
    if (issue_pc_o !== 32'h308 || issue_rd_tag_o !== 2) begin
      errors++;
      $display("FAIL stall_hold got pc=%h rd=%0d want 308/2",
               issue_pc_o, issue_rd_tag_o);
    end
    issue_ready_i = 1; tick(); issue_ready_i = 0; #1;
    checks++;
    if (issue_valid_o !== 1 || issue_pc_o !== 32'h300 ||
        issue_rs1_val_o !== 32'hA0 || count_o !== 3) begin
      errors++;
      $display("FAIL stall_next got pc=%h rs1=%h cnt=%0d want 300/a0/3",
               issue_pc_o, issue_rs1_val_o, count_o);
    end
  endtask

  task automatic test_full();
    do_flush();
    set_disp(32'h400, 1, 0, 32'h41, 1, 0, 0, 1); tick();
    for (int i = 1; i < 4; i++) begin
      set_disp(32'h400 + 4 * i, 0, 14, 0, 1, 0, 0, 1); tick();
    end
    idle(); set_disp(32'h500, 1, 0, 1, 1, 0, 2, 5);
    issue_ready_i = 1; #1;
    checks++;
    if (disp_ready_o !== 0 || issue_valid_o !== 1) begin
      errors++;
      $display("FAIL full_refuse got rdy=%b v=%b want 0/1",
               disp_ready_o, issue_valid_o);
    end
    tick(); issue_ready_i = 0; #1;
    checks++;
    if (count_o !== 3 || disp_ready_o !== 1) begin
      errors++;
      $display("FAIL full_after got cnt=%0d rdy=%b want 3/1",
               count_o, disp_ready_o);
    end
    tick(); idle(); #1;
    checks++;
    if (count_o !== 4 || issue_pc_o !== 32'h500) begin
      errors++;
      $display("FAIL full_accept got cnt=%0d pc=%h want 4/500",
               count_o, issue_pc_o);
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 3; i++) begin
      set_disp(32'h600 + 4 * i, 0, 14, 0, 1, 0, 0, 1); tick();
    end
    idle(); #1;
    checks++;
    if (count_o !== 3) begin
      errors++; $display("FAIL flush_pre got cnt=%0d want 3", count_o);
    end
    set_disp(32'h700, 1, 0, 1, 1, 0, 1, 1); flush_i = 1;
    cdb_valid_i = 1; cdb_tag_i = 14; cdb_val_i = 32'h77; tick();
    idle(); #1;
    checks++;
    if (count_o !== 0 || issue_valid_o !== 0 || disp_ready_o !== 1) begin
      errors++;
      $display("FAIL flush got cnt=%0d v=%b want 0/0",
               count_o, issue_valid_o);
    end
    tick();
    checks++;
    if (count_o !== 0 || issue_valid_o !== 0) begin
      errors++;
      $display("FAIL flush_drop got cnt=%0d v=%b want 0/0",
               count_o, issue_valid_o);
    end
  endtask

  task automatic test_random();
    int     sel;
    bit     ev, dok;
    m_ent_t e;
    logic [135:0] exp_d;
    idle(); reset_i = 1; tick(); reset_i = 0;
    mq.delete(); mlock = 0; mlidx = 0;
    for (int c = 0; c < 3000; c++) begin
      flush_i        = ($urandom_range(63) == 0);
      disp_valid_i   = $urandom_range(1);
      disp_pc_i      = $urandom; disp_inst_i = $urandom;
      disp_rd_tag_i  = 4'($urandom);
      disp_rs1_rdy_i = $urandom_range(1);
      disp_rs1_tag_i = 4'($urandom_range(7));
      disp_rs1_val_i = $urandom;
      disp_rs2_rdy_i = $urandom_range(1);
      disp_rs2_tag_i = 4'($urandom_range(7));
      disp_rs2_val_i = $urandom;
      cdb_valid_i    = $urandom_range(1);
      cdb_tag_i      = 4'($urandom_range(7));
      cdb_val_i      = $urandom;
      issue_ready_i  = ($urandom_range(2) != 0);
      #1;
      sel = -1;
      if (mlock) sel = mlidx;
      else foreach (mq[k]) if (sel < 0 && mq[k].r1 && mq[k].r2) sel = k;
      ev = (sel >= 0);
      exp_d = '0;
      if (ev) exp_d = {mq[sel].pc, mq[sel].inst, mq[sel].v1,
                       mq[sel].v2, 4'h0, mq[sel].rd};
      checks++;
      if (count_o !== 3'(mq.size()) ||
          disp_ready_o !== (mq.size() < 4)) begin
        errors++;
        $display("FAIL rnd_count c=%0d got %0d/%b want %0d",
                 c, count_o, disp_ready_o, mq.size());
      end
      checks++;
      if (issue_valid_o !== ev) begin
        errors++;
        $display("FAIL rnd_valid c=%0d got %b want %b",
                 c, issue_valid_o, ev);
      end
      checks++;
      if ({issue_pc_o, issue_inst_o, issue_rs1_val_o, issue_rs2_val_o,
           4'h0, issue_rd_tag_o} !== exp_d) begin
        errors++;
        $display("FAIL rnd_data c=%0d got pc=%h rs1=%h rs2=%h want %h",
                 c, issue_pc_o, issue_rs1_val_o, issue_rs2_val_o, exp_d);
      end
      @(posedge clk);
      if (flush_i) begin
        mq.delete(); mlock = 0;
      end else begin
        dok = disp_valid_i && (mq.size() < 4);
        if (ev && issue_ready_i) begin
          mq.delete(sel); mlock = 0;
        end else if (ev) begin
          mlock = 1; mlidx = sel;
        end
        for (int k = 0; k <= mq.size(); k++) begin
          if (k == mq.size()) begin
            if (!dok) break;
            e.pc = disp_pc_i; e.inst = disp_inst_i; e.rd = disp_rd_tag_i;
            e.r1 = disp_rs1_rdy_i; e.t1 = disp_rs1_tag_i;
            e.v1 = disp_rs1_val_i;
            e.r2 = disp_rs2_rdy_i; e.t2 = disp_rs2_tag_i;
            e.v2 = disp_rs2_val_i;
          end else begin
            e = mq[k];
          end
          if (cdb_valid_i && !e.r1 && e.t1 == cdb_tag_i) begin
            e.r1 = 1; e.v1 = cdb_val_i;
          end
          if (cdb_valid_i && !e.r2 && e.t2 == cdb_tag_i) begin
            e.r2 = 1; e.v2 = cdb_val_i;
          end
          if (k == mq.size()) begin
            mq.push_back(e); break;
          end
          mq[k] = e;
        end
      end
      #1;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_stall_hold();
    test_full();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
